// File: rtl/password_fsm.sv
// password_fsm: password-entry controller.
// Synchronizes and debounces a raw ENTER button, captures one digit per accepted
// press, checks four digits against PASSWORD and shows DONE or ERROR for
// HOLD_CYCLES cycles before returning to IDLE.
// Optional lockout after MAX_FAILS consecutive failures: define PASSWORD_LOCKOUT_EN.
module password_fsm #(
  parameter logic [15:0] PASSWORD        = 16'h1234,
  parameter int          DEBOUNCE_CYCLES = 4,
  parameter int          HOLD_CYCLES     = 8,
  parameter int          MAX_FAILS       = 3,
  parameter int          LOCK_CYCLES     = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] digit_in,
  input  logic       enter,
  output logic [3:0] state,
  output logic       press,
  output logic [1:0] fail_count
);

  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_DIGIT_2 = 4'd1,
    S_DIGIT_3 = 4'd2,
    S_DIGIT_4 = 4'd3,
    S_DONE    = 4'd4,
`ifdef PASSWORD_LOCKOUT_EN
    S_ERROR   = 4'd5,
    S_LOCKED  = 4'd6
`else
    S_ERROR   = 4'd5
`endif
  } state_t;

  logic              r_sync1;
  logic              r_sync2;
  logic [DB_W-1:0]   r_db_cnt;
  logic              r_db_level;
  logic              r_press;
  state_t            r_state;
  logic              r_mismatch;
  logic [HOLD_W-1:0] r_hold_cnt;
  logic [1:0]        r_fail;

  state_t            w_state_nxt;
  logic              w_mismatch_nxt;
  logic [HOLD_W-1:0] w_hold_nxt;
  logic [1:0]        w_fail_nxt;
  logic [3:0]        w_exp_nibble;
  logic              w_digit_bad;

`ifdef PASSWORD_LOCKOUT_EN
  localparam int LOCK_W = $clog2(LOCK_CYCLES + 1);
  logic [LOCK_W-1:0] r_lock_cnt;
  logic [LOCK_W-1:0] w_lock_nxt;
`endif

  // Two-flop synchronizer for the asynchronous button.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= enter;
      r_sync2 <= r_sync1;
    end
  end

  // Debounce: flip the level after DEBOUNCE_CYCLES consecutive differing samples;
  // a rising flip produces the one-cycle press pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_db_cnt   <= '0;
      r_db_level <= 1'b0;
      r_press    <= 1'b0;
    end else if (r_sync2 == r_db_level) begin
      r_db_cnt <= '0;
      r_press  <= 1'b0;
    end else if (r_db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
      r_db_cnt   <= '0;
      r_db_level <= r_sync2;
      r_press    <= r_sync2;
    end else begin
      r_db_cnt <= r_db_cnt + DB_W'(1);
      r_press  <= 1'b0;
    end
  end

  // Select the password nibble that belongs to the digit being entered.
  always_comb begin
    w_exp_nibble = PASSWORD[15:12];
    case (r_state)
      S_IDLE:    w_exp_nibble = PASSWORD[15:12];
      S_DIGIT_2: w_exp_nibble = PASSWORD[11:8];
      S_DIGIT_3: w_exp_nibble = PASSWORD[7:4];
      S_DIGIT_4: w_exp_nibble = PASSWORD[3:0];
      default:   w_exp_nibble = PASSWORD[15:12];
    endcase
    w_digit_bad = (digit_in != w_exp_nibble);
  end

  // Next-state logic: digit collection, result hold, failure tracking.
  always_comb begin
    w_state_nxt    = r_state;
    w_mismatch_nxt = r_mismatch;
    w_hold_nxt     = r_hold_cnt;
    w_fail_nxt     = r_fail;
`ifdef PASSWORD_LOCKOUT_EN
    w_lock_nxt     = r_lock_cnt;
`endif
    case (r_state)
      S_IDLE: begin
        if (r_press) begin
          w_mismatch_nxt = w_digit_bad;
          w_state_nxt    = S_DIGIT_2;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_DIGIT_2, S_DIGIT_3: begin
        if (r_press) begin
          w_mismatch_nxt = r_mismatch | w_digit_bad;
          w_state_nxt    = (r_state == S_DIGIT_2) ? S_DIGIT_3 : S_DIGIT_4;
        end else begin
          w_state_nxt = r_state;
        end
      end
      S_DIGIT_4: begin
        if (r_press) begin
          w_hold_nxt = HOLD_W'(HOLD_CYCLES - 1);
          if (r_mismatch || w_digit_bad) begin
            w_state_nxt = S_ERROR;
            w_fail_nxt  = (r_fail == 2'd3) ? 2'd3 : (r_fail + 2'd1);
          end else begin
            w_state_nxt = S_DONE;
            w_fail_nxt  = 2'd0;
          end
        end else begin
          w_state_nxt = S_DIGIT_4;
        end
      end
      S_DONE: begin
        // Presses are ignored while the result is on display.
        if (r_hold_cnt == '0) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_hold_nxt = r_hold_cnt - HOLD_W'(1);
        end
      end
      S_ERROR: begin
        if (r_hold_cnt == '0) begin
`ifdef PASSWORD_LOCKOUT_EN
          if (int'(r_fail) >= MAX_FAILS) begin
            w_state_nxt = S_LOCKED;
            w_lock_nxt  = LOCK_W'(LOCK_CYCLES - 1);
          end else begin
            w_state_nxt = S_IDLE;
          end
`else
          w_state_nxt = S_IDLE;
`endif
        end else begin
          w_hold_nxt = r_hold_cnt - HOLD_W'(1);
        end
      end
`ifdef PASSWORD_LOCKOUT_EN
      S_LOCKED: begin
        if (r_lock_cnt == '0) begin
          w_state_nxt = S_IDLE;
          w_fail_nxt  = 2'd0;
        end else begin
          w_lock_nxt = r_lock_cnt - LOCK_W'(1);
        end
      end
`endif
      default: begin
        w_state_nxt    = S_IDLE;
        w_mismatch_nxt = 1'b0;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_mismatch <= 1'b0;
      r_hold_cnt <= '0;
      r_fail     <= 2'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_mismatch <= w_mismatch_nxt;
      r_hold_cnt <= w_hold_nxt;
      r_fail     <= w_fail_nxt;
    end
  end

`ifdef PASSWORD_LOCKOUT_EN
  // Lockout duration counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_lock_cnt <= '0;
    end else begin
      r_lock_cnt <= w_lock_nxt;
    end
  end
`endif

  assign state      = r_state;
  assign press      = r_press;
  assign fail_count = r_fail;

endmodule

// File: tb/tb_password_fsm.sv
// Self-checking bench for password_fsm: table of full codes, a press scoreboard,
// and hand-written reset, bounce, saturation and lockout sequences.
module tb_password_fsm;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] digit_in;
  logic       enter;
  logic [3:0] state;
  logic       press;
  logic [1:0] fail_count;

  password_fsm dut (
    .clk        (clk),
    .rst        (rst),
    .digit_in   (digit_in),
    .enter      (enter),
    .state      (state),
    .press      (press),
    .fail_count (fail_count)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Reference model state.
  logic [15:0] pw = 16'h1234;
  int m_state = 0;
  logic m_mis = 1'b0;
  int m_fail = 0;
  int exp_after_hold = 0;

  // Scoreboard: expected state after each accepted press.
  int sb_q[$];
  logic mon_pending = 1'b0;
  int mon_exp = 0;
  int press_cnt = 0;

  // Pop one expectation per press pulse and compare the state one cycle later.
  always @(negedge clk) begin
    if (mon_pending) begin
      check("sb_state", state, mon_exp);
      mon_pending = 1'b0;
    end
    if (press === 1'b1) begin
      press_cnt++;
      if (sb_q.size() == 0) begin
        n_total++;
        $display("FAIL sb_unexpected_press: got press with empty queue, expected none");
      end else begin
        mon_exp = sb_q.pop_front();
        mon_pending = 1'b1;
      end
    end
  end

  // Measure how long DONE/ERROR and LOCKED last and where they exit to.
  int hold_run = 0;
  int lock_run = 0;
  logic [3:0] prev_state = 4'd0;
  logic saw6 = 1'b0;
  always @(negedge clk) begin
    if (state === 4'd6) saw6 = 1'b1;
    if (state === 4'd4 || state === 4'd5) hold_run++;
    else if (prev_state == 4'd4 || prev_state == 4'd5) begin
      check("hold_len", hold_run, 8);
      check("hold_exit", state, exp_after_hold);
      hold_run = 0;
    end
    if (state === 4'd6) lock_run++;
    else if (prev_state == 4'd6) begin
      check("lock_len", lock_run, 32);
      check("lock_exit", state, 0);
      lock_run = 0;
    end
    prev_state = state;
  end

  task automatic model_press(input logic [3:0] d, output int nxt);
    logic [3:0] nib;
    nib = pw[15-4*m_state -: 4];
    case (m_state)
      0: begin m_mis = (d != nib); nxt = 1; m_state = 1; end
      1, 2: begin m_mis = m_mis | (d != nib); nxt = m_state + 1; m_state = nxt; end
      default: begin
        if (m_mis || d != nib) begin
          nxt = 5;
          if (m_fail < 3) m_fail++;
        end else begin
          nxt = 4;
          m_fail = 0;
        end
        exp_after_hold = 0;
`ifdef PASSWORD_LOCKOUT_EN
        if (m_fail >= 3 && nxt == 5) exp_after_hold = 6;
`endif
        m_state = 0;
      end
    endcase
  endtask

  // Hold enter high for hi cycles, low for lo; check press latency and width.
  task automatic pulse_enter(input logic [3:0] d, input int hi, input int lo,
                             output logic [3:0] st7);
    st7 = state;
    @(negedge clk);
    digit_in = d;
    enter = 1'b1;
    for (int e = 1; e <= hi; e++) begin
      @(negedge clk);
      if (e == 5) check("press_early", press, 0);
      if (e == 6) check("press_edge6", press, 1);
      if (e == 7) begin check("press_width", press, 0); st7 = state; end
    end
    enter = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  task automatic press_digit(input logic [3:0] d, output logic [3:0] st7);
    int nxt;
    model_press(d, nxt);
    sb_q.push_back(nxt);
    pulse_enter(d, 10, 10, st7);
  endtask

  task automatic enter_code(input logic [15:0] code, output logic [3:0] st);
    for (int k = 0; k < 4; k++) press_digit(code[15-4*k -: 4], st);
  endtask

  typedef struct {
    logic [15:0] code;
    int          exp_state;
    int          exp_fail;
  } vec_t;
  vec_t tbl[7];

  initial begin
    logic [3:0] st;
    int base;
    tbl[0] = '{16'h1234, 4, 0};
    tbl[1] = '{16'h1294, 5, 1};
    tbl[2] = '{16'hA234, 5, 2};
    tbl[3] = '{16'h1234, 4, 0};
    tbl[4] = '{16'h0000, 5, 1};
    tbl[5] = '{16'h1235, 5, 2};
    tbl[6] = '{16'h1234, 4, 0};

    // Reset with enter toggling.
    rst = 1'b0;
    enter = 1'b0;
    digit_in = 4'h0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      enter = ~enter;
      check("rst_state", state, 0);
      check("rst_press", press, 0);
      check("rst_fail", fail_count, 0);
    end
    enter = 1'b0;
    rst = 1'b1;
    base = press_cnt;
    repeat (10) @(negedge clk);
    check("post_rst_no_press", press_cnt - base, 0);

    // Table of complete codes.
    for (int i = 0; i < 7; i++) begin
      enter_code(tbl[i].code, st);
      check("tbl_state", st, tbl[i].exp_state);
      check("tbl_fail", fail_count, tbl[i].exp_fail);
    end

    // Three consecutive wrong codes.
    for (int k = 0; k < 3; k++) begin
      enter_code(16'h1294, st);
      check("wrong_state", st, 5);
      check("wrong_fail", fail_count, k + 1);
    end
`ifdef PASSWORD_LOCKOUT_EN
    // Press during LOCKED is ignored.
    sb_q.push_back(6);
    pulse_enter(4'h1, 10, 10, st);
    repeat (12) @(negedge clk);
    m_fail = 0;
    check("lock_fail_clear", fail_count, 0);
    check("locked_seen", saw6, 1);
`else
    enter_code(16'h1294, st);
    check("sat_fail", fail_count, 3);
    check("locked_seen", saw6, 0);
`endif
    enter_code(16'h1234, st);
    check("recover_state", st, 4);
    check("recover_fail", fail_count, 0);

    // Bouncy first digit, then a long hold: exactly one press.
    base = press_cnt;
    begin
      int nxt;
      model_press(4'h1, nxt);
      sb_q.push_back(nxt);
    end
    digit_in = 4'h1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      enter = ~enter;
    end
    enter = 1'b1;
    repeat (110) @(negedge clk);
    enter = 1'b0;
    repeat (10) @(negedge clk);
    check("bounce_press_count", press_cnt - base, 1);
    check("bounce_state", state, 1);
    press_digit(4'h2, st);
    press_digit(4'h3, st);
    press_digit(4'h4, st);
    check("bounce_code_done", st, 4);

    // Asynchronous reset in the middle of an entry.
    press_digit(4'h1, st);
    press_digit(4'h2, st);
    check("mid_state", state, 2);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("async_rst_state", state, 0);
    @(negedge clk);
    rst = 1'b1;
    m_state = 0;
    m_mis = 1'b0;
    enter_code(16'h1234, st);
    check("after_rst_done", st, 4);
    repeat (12) @(negedge clk);

    check("sb_drained", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
